// File: rtl/ac_unit_drain_controller.sv
// ac_unit_drain_controller: drains the capture unit sample buffer
// over its register port and streams 32-bit words on valid/ready.
// Ports: clk_i, rst_i (async, active-high), enable_i;
//   read_o/read_address_o/read_data_i/read_error_i = register port;
//   data_o/valid_o/ready_i/last_o = stream; busy_o, error_o, word_count_o.
// Optional: define AC_DRAIN_PACK_EN to pack two 16-bit samples per word.

package ac_unit_pkg;
  typedef enum logic [1:0] {
    CAPTURE_UNIT_STATUS        = 2'd0,
    CAPTURE_UNIT_SAMPLE_BUFFER = 2'd1
  } capture_unit_registers_t;
endpackage

module ac_unit_drain_controller
  import ac_unit_pkg::*;
#(
  parameter int unsigned BURST_LENGTH   = 16,
  parameter int unsigned BACKOFF_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  output logic                    read_o,
  output capture_unit_registers_t read_address_o,
  input  logic [31:0]             read_data_i,
  input  logic                    read_error_i,
  output logic [31:0]             data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    error_o,
  output logic [15:0]             word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_POP,
    S_EMIT,
    S_BACKOFF
  } state_t;

  localparam logic [7:0] BL_M1 = 8'(BURST_LENGTH - 1);
  localparam logic [7:0] BO_M1 = 8'(BACKOFF_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  bo_q, bo_d;
  logic        err_q, err_d;
  logic [15:0] word_count_q, word_count_d;
  logic        held;
  logic        is_last;
  logic        empty;
  logic [15:0] sample;
  logic        unused_rd;

`ifdef AC_DRAIN_PACK_EN
  logic        half_q, half_d;
  logic [15:0] low_q, low_d;
  logic        flush_q, flush_d;
  assign held    = half_q;
  assign is_last = (burst_q == BL_M1) || flush_q;
`else
  assign held    = 1'b0;
  assign is_last = (burst_q == BL_M1);
`endif

  assign empty     = read_data_i[0];
  assign sample    = read_data_i[15:0];
  // Upper data half and the full flag carry nothing we act on.
  assign unused_rd = ^{read_data_i[31:16], read_data_i[1]};

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    burst_d      = burst_q;
    bo_d         = 8'd0;
    err_d        = err_q;
    word_count_d = word_count_q;
`ifdef AC_DRAIN_PACK_EN
    half_d       = half_q;
    low_d        = low_q;
    flush_d      = flush_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable_i && !err_q) state_d = S_POLL;
      end
      S_POLL: begin
        if (read_error_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef AC_DRAIN_PACK_EN
          half_d  = 1'b0;
`endif
        end else if (!empty) begin
          state_d = S_POP;
        end else if (enable_i) begin
          state_d = S_BACKOFF;
`ifdef AC_DRAIN_PACK_EN
        end else if (half_q) begin
          // Buffer ran dry on disable: flush the lone low half.
          word_d  = {16'h0000, low_q};
          half_d  = 1'b0;
          flush_d = 1'b1;
          state_d = S_EMIT;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        if (read_error_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef AC_DRAIN_PACK_EN
          half_d  = 1'b0;
`endif
        end else begin
`ifdef AC_DRAIN_PACK_EN
          if (!half_q) begin
            low_d   = sample;
            half_d  = 1'b1;
            state_d = S_POLL;
          end else begin
            word_d  = {sample, low_q};
            half_d  = 1'b0;
            flush_d = 1'b0;
            state_d = S_EMIT;
          end
`else
          word_d  = {16'h0000, sample};
          state_d = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (ready_i) begin
          word_count_d = word_count_q + 16'd1;
          if (is_last) begin
            burst_d = 8'd0;
            state_d = S_BACKOFF;
`ifdef AC_DRAIN_PACK_EN
            flush_d = 1'b0;
`endif
          end else begin
            burst_d = burst_q + 8'd1;
            state_d = (enable_i || held) ? S_POLL : S_IDLE;
          end
        end
      end
      S_BACKOFF: begin
        if (bo_q == BO_M1) begin
          state_d = (!enable_i && !held) ? S_IDLE : S_POLL;
        end else begin
          bo_d = bo_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      word_q       <= 32'h0;
      burst_q      <= 8'd0;
      bo_q         <= 8'd0;
      err_q        <= 1'b0;
      word_count_q <= 16'h0;
`ifdef AC_DRAIN_PACK_EN
      half_q       <= 1'b0;
      low_q        <= 16'h0;
      flush_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      burst_q      <= burst_d;
      bo_q         <= bo_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
`ifdef AC_DRAIN_PACK_EN
      half_q       <= half_d;
      low_q        <= low_d;
      flush_q      <= flush_d;
`endif
    end
  end

  assign read_o         = (state_q == S_POLL) || (state_q == S_POP);
  assign read_address_o = (state_q == S_POP) ? CAPTURE_UNIT_SAMPLE_BUFFER
                                             : CAPTURE_UNIT_STATUS;
  assign valid_o        = (state_q == S_EMIT);
  assign last_o         = valid_o && is_last;
  assign busy_o         = (state_q != S_IDLE);
  assign data_o         = word_q;
  assign error_o        = err_q;
  assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_ac_unit_drain_controller.sv
// Bench for ac_unit_drain_controller: cycle table, corner sequences,
// and a randomized run against a queue-based stream model.

module tb_ac_unit_drain_controller;
  import ac_unit_pkg::*;

  localparam int BL = 4;
  localparam int BO = 2;

  logic clk = 1'b0;
  logic rst, enable, ready, read_err;
  logic read_o, valid_o, last_o, busy_o, error_o;
  capture_unit_registers_t read_address_o;
  logic [31:0] read_data, data_o;
  logic [15:0] word_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] fifo[$];
  logic [15:0] mq[$];
  logic [15:0] head;
  logic        empty;

  always #5 clk = ~clk;

  ac_unit_drain_controller #(
    .BURST_LENGTH(BL),
    .BACKOFF_CYCLES(BO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .read_o(read_o),
    .read_address_o(read_address_o),
    .read_data_i(read_data),
    .read_error_i(read_err),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready),
    .last_o(last_o),
    .busy_o(busy_o),
    .error_o(error_o),
    .word_count_o(word_count_o)
  );

  // Capture unit model: upper data bits are junk to expose zero-extension.
  assign read_data = (read_address_o == CAPTURE_UNIT_SAMPLE_BUFFER)
                   ? {16'hA5A5, head} : {30'd0, 1'b0, empty};

  function automatic void refresh();
    empty = (fifo.size() == 0);
    head  = empty ? 16'h0 : fifo[0];
  endfunction

  task automatic push(input logic [15:0] s);
    fifo.push_back(s);
    refresh();
  endtask

  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      pend = read_o && (read_address_o == CAPTURE_UNIT_SAMPLE_BUFFER);
      @(posedge clk);
      #1;
      if (pend && !rst && fifo.size() > 0) begin
        void'(fifo.pop_front());
        refresh();
      end
    end
  end

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    enable = 1'b0;
    ready = 1'b0;
    read_err = 1'b0;
    fifo.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 300 && !valid_o; i++) @(negedge clk);
    chk(nm, {39'd0, valid_o}, 40'd1);
  endtask

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        rd;
    logic        sb;
    logic        vld;
    logic        lst;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(logic rd, logic sb, logic vld,
                              logic lst, logic [31:0] d);
    return '{1'b1, 1'b1, rd, sb, vld, lst, d};
  endfunction

  vec_t tbl[27];
  vec_t vp, vq, vb;

  initial begin
    logic [31:0] expw, pd;
    logic        pv, ph, pl, hs;
    int          bpos;
    logic [15:0] mcnt, s;

    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] expw, pd;
    logic        pv, ph, pl, hs;
    int          bpos;
    logic [15:0] mcnt, s;

    // Reset state
    reset_dut();
    chk("rst_read", {39'd0, read_o}, 40'd0);
    chk("rst_addr", {38'd0, read_address_o}, {38'd0, CAPTURE_UNIT_STATUS});
    chk("rst_data", {8'd0, data_o}, 40'd0);
    chk("rst_valid", {39'd0, valid_o}, 40'd0);
    chk("rst_last", {39'd0, last_o}, 40'd0);
    chk("rst_busy", {39'd0, busy_o}, 40'd0);
    chk("rst_err", {39'd0, error_o}, 40'd0);
    chk("rst_cnt", {24'd0, word_count_o}, 40'd0);

`ifndef AC_DRAIN_PACK_EN
    // Cycle table: six samples, burst of 4, backoff of 2.
    vp = mk(1, 0, 0, 0, 0);
    vq = mk(1, 1, 0, 0, 0);
    vb = mk(0, 0, 0, 0, 0);
    tbl = '{vp, vq, mk(0, 0, 1, 0, 32'h1),
            vp, vq, mk(0, 0, 1, 0, 32'h2),
            vp, vq, mk(0, 0, 1, 0, 32'h3),
            vp, vq, mk(0, 0, 1, 1, 32'h4),
            vb, vb,
            vp, vq, mk(0, 0, 1, 0, 32'h5),
            vp, vq, mk(0, 0, 1, 0, 32'h6),
            vp, vb, vb, vp, vb, vb, vp};
    for (int i = 1; i <= 6; i++) push(16'(i));
    enable = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {2'b11, read_o,
           read_address_o == CAPTURE_UNIT_SAMPLE_BUFFER,
           valid_o, last_o, valid_o ? data_o : 32'h0},
          tbl[i]);
      enable = tbl[i].en;
      ready = tbl[i].rdy;
    end
    chk("tbl_count", {24'd0, word_count_o}, 40'd6);
`else
    // Pack path with a flushed odd sample.
    reset_dut();
    push(16'hAAAA);
    push(16'hBBBB);
    push(16'hCCCC);
    enable = 1'b1;
    ready = 1'b1;
    wait_valid("pack_v1");
    chk("pack_w1", {8'd0, data_o}, {8'd0, 32'hBBBBAAAA});
    @(negedge clk);
    for (int i = 0; i < 100 && fifo.size() != 0; i++) @(negedge clk);
    enable = 1'b0;
    wait_valid("pack_v2");
    chk("flush_w", {7'd0, last_o, data_o}, {7'd0, 1'b1, 32'h0000CCCC});
    for (int i = 0; i < 50 && busy_o; i++) @(negedge clk);
    chk("flush_idle", {39'd0, busy_o}, 40'd0);
    chk("flush_cnt", {24'd0, word_count_o}, 40'd2);
`endif

    // Backpressure
    reset_dut();
    push(16'h1234);
`ifdef AC_DRAIN_PACK_EN
    push(16'h5678);
    expw = 32'h56781234;
`else
    expw = 32'h00001234;
`endif
    enable = 1'b1;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {5'd0, read_o, valid_o, last_o, data_o},
          {5'd0, 1'b0, 1'b1, 1'b0, expw});
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", {23'd0, valid_o, word_count_o}, {23'd0, 1'b0, 16'd1});

    // Read error during POP
    reset_dut();
    push(16'h0042);
    enable = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 100 &&
         !(read_o && read_address_o == CAPTURE_UNIT_SAMPLE_BUFFER); i++)
      @(negedge clk);
    chk("err_pop", {39'd0, read_o}, 40'd1);
    read_err = 1'b1;
    @(negedge clk);
    read_err = 1'b0;
    chk("err_set", {38'd0, error_o, busy_o}, {38'd0, 2'b10});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_stuck", {38'd0, busy_o, read_o}, 40'd0);
    end
    reset_dut();
    chk("err_clr", {39'd0, error_o}, 40'd0);

    // Counter wrap
    @(negedge clk);
    force dut.word_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_count_q;
    push(16'h0007);
`ifdef AC_DRAIN_PACK_EN
    push(16'h0008);
`endif
    enable = 1'b1;
    ready = 1'b1;
    wait_valid("wrap_valid");
    @(negedge clk);
    chk("wrap_cnt", {24'd0, word_count_o}, 40'd0);

    // Asynchronous reset while a word is pending
    reset_dut();
    push(16'h0099);
`ifdef AC_DRAIN_PACK_EN
    push(16'h0098);
`endif
    enable = 1'b1;
    wait_valid("ar_valid");
    #2;
    rst = 1'b1;
    #1;
    chk("ar_outs", {3'd0, read_o, valid_o, last_o, busy_o, error_o, data_o},
        40'd0);
    chk("ar_cnt", {24'd0, word_count_o}, 40'd0);
    enable = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_after", {23'd0, valid_o, word_count_o}, 40'd0);

    // Randomized run against the stream model
    reset_dut();
    mq.delete();
    enable = 1'b1;
    pv = 1'b0;
    ph = 1'b0;
    pl = 1'b0;
    pd = 32'h0;
    bpos = 0;
    mcnt = 16'h0;
    for (int c = 0; c < 4500; c++) begin
      @(negedge clk);
      if (pv && !ph) begin
        chk("rnd_hold", {7'd0, valid_o, last_o, data_o},
            {7'd0, 1'b1, pl, pd});
      end else if (valid_o) begin
`ifdef AC_DRAIN_PACK_EN
        expw = (mq.size() >= 2) ? {mq[1], mq[0]} : 32'hDEADBEEF;
`else
        expw = (mq.size() >= 1) ? {16'h0, mq[0]} : 32'hDEADBEEF;
`endif
        chk("rnd_word", {7'd0, last_o, data_o},
            {7'd0, bpos == BL - 1, expw});
      end
      chk("rnd_cnt", {24'd0, word_count_o}, {24'd0, mcnt});
      if (valid_o) chk("rnd_rdvld", {39'd0, read_o}, 40'd0);
      if (c < 3000) begin
        ready = ($urandom_range(0, 3) != 0);
`ifndef AC_DRAIN_PACK_EN
        if ($urandom_range(0, 24) == 0) enable = ~enable;
`endif
        if ($urandom_range(0, 5) == 0) begin
          s = 16'($urandom);
          push(s);
          mq.push_back(s);
        end
      end else begin
        ready = 1'b1;
        enable = 1'b1;
      end
      hs = valid_o && ready;
      if (hs) begin
        if (mq.size() > 0) void'(mq.pop_front());
`ifdef AC_DRAIN_PACK_EN
        if (mq.size() > 0) void'(mq.pop_front());
`endif
        mcnt = mcnt + 16'd1;
        bpos = (bpos == BL - 1) ? 0 : bpos + 1;
      end
      pv = valid_o;
      ph = hs;
      pd = data_o;
      pl = last_o;
    end
`ifdef AC_DRAIN_PACK_EN
    chk("rnd_drain", {39'd0, mq.size() > 1}, 40'd0);
`else
    chk("rnd_drain", {8'd0, 32'(mq.size())}, 40'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_unit_drain_controller.md
# ac_unit_drain_controller

Sequencer that drains the audio capture unit's sample buffer through the unit's register read port and streams the samples out as 32-bit words on a valid/ready interface. It sits between the capture unit's register block and a downstream consumer (DMA write channel or a packing FIFO toward memory), replacing CPU polling. It polls the status register, pops samples, optionally packs two 16-bit samples per word, and inserts a back-off gap after each burst so the register port is shared fairly.

## Interface

- BURST_LENGTH, 16: words emitted per burst before back-off; valid range 1..255.
- BACKOFF_CYCLES, 8: idle cycles inserted after a burst or an empty poll; valid range 1..255.
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- enable_i  input  1  level; drain while high.
- read_o  output  1  register read strobe to the capture unit.
- read_address_o  output  capture_unit_registers_t  register selected, CAPTURE_UNIT_STATUS or CAPTURE_UNIT_SAMPLE_BUFFER only.
- read_data_i  input  32  register read data, valid in the same cycle as read_o.
- read_error_i  input  1  read error, qualified by read_o.
- data_o  output  32  stream word.
- valid_o  output  1  stream word valid.
- ready_i  input  1  consumer accepts word.
- last_o  output  1  final word of a burst or the flush word.
- busy_o  output  1  state is not IDLE.
- error_o  output  1  sticky; set on read_error_i, cleared only by reset.
- word_count_o  output  16  words accepted since reset; wraps modulo 2^16.

## Operation

- Status word layout: bit 0 = buffer empty, bit 1 = buffer full. Samples are in read_data_i[15:0].
- Moore FSM with states IDLE, POLL, POP, EMIT, BACKOFF. read_o and read_address_o are decoded from the state register only.
- IDLE: if enable_i is high and error_o is low, go to POLL.
- POLL: read_o=1 with address STATUS.
  - read_error_i: set error_o, drop any held half word, go to IDLE.
  - Not empty: go to POP.
  - Empty, enable_i low, half word held: go to EMIT as a flush.
  - Empty, enable_i low, no half word: go to IDLE.
  - Empty, enable_i high: go to BACKOFF.
- POP: read_o=1 with address SAMPLE_BUFFER; exactly one sample is popped per POP cycle.
  - read_error_i is handled as in POLL.
  - Packing, no half held: store the sample as the low half, set half_valid, go to POLL.
  - Packing, half held: word = {sample, low}, clear half_valid, go to EMIT.
  - No packing: word = {16'h0000, sample}, go to EMIT.
- EMIT: valid_o=1. data_o and last_o stay stable until ready_i.
  - A flush word is {16'h0000, low}.
  - last_o = (burst_cnt == BURST_LENGTH-1) or flush.
  - On handshake: increment word_count_o and burst_cnt.
  - If last: reset burst_cnt and go to BACKOFF.
  - Otherwise: go to POLL if enable_i is high, else IDLE. A held half word always routes to POLL so it can be flushed.
- BACKOFF: count BACKOFF_CYCLES cycles, then go to POLL. Go to IDLE instead if enable_i is low and no half word is held.
- enable_i falling mid-operation: the current state completes. Words in EMIT are never dropped and valid_o never deasserts without a handshake.
- The 8-bit burst counter is compared against BURST_LENGTH-1.

## Timing

- Reset values: read_o=0, read_address_o=CAPTURE_UNIT_STATUS, data_o=0, valid_o=0, last_o=0, busy_o=0, error_o=0, word_count_o=0. Internal half_valid=0, burst_cnt=0.
- Reset mid-operation: all state clears immediately. A held half word and any pending word are discarded.
- Latency, enable_i rising to first POLL: 1 cycle.
- No-pack path: POLL, POP, EMIT, so valid_o asserts 2 cycles after POLL is entered.
- Pack path: POLL, POP, POLL, POP, EMIT, so valid_o asserts 4 cycles after POLL is entered.
- Maximum throughput with ready_i held high: one word per 3 cycles (no pack) or per 5 cycles (pack), plus BACKOFF_CYCLES per burst.
- Empty buffer while enabled: one POLL every BACKOFF_CYCLES+1 cycles.
- word_count_o updates in the cycle after the handshake.

## Configuration

- AC_DRAIN_PACK_EN defined: two samples are packed per word, first sample in the low half. The held half word is flushed zero-extended when enable_i drops on an empty buffer.
- AC_DRAIN_PACK_EN undefined: one sample per word, zero-extended. half_valid logic is removed, and the flush path does not exist.

## Test plan

- Reset mid-EMIT with valid_o=1: assert rst_i asynchronously. All outputs return to their reset values without a clock edge, and the pending word is never accepted.
- No pack, BURST_LENGTH=4, BACKOFF_CYCLES=2, FIFO holds 0x0001..0x0006, ready_i=1:
  - Words 0x00000001..0x00000004 are emitted, with last_o on the 4th.
  - 2 BACKOFF cycles follow.
  - Words 0x00000005..0x00000006 are emitted.
  - The FSM then polls every 3 cycles and word_count_o=6.
- Pack, FIFO holds 0xAAAA, 0xBBBB, 0xCCCC, then enable_i drops:
  - data_o=0xBBBBAAAA.
  - Then a flush word 0x0000CCCC with last_o=1.
  - Then IDLE with busy_o=0.
- Backpressure: ready_i=0 for 10 cycles during EMIT. data_o, valid_o and last_o stay stable, no read_o is issued, and the word is accepted on the cycle ready_i=1.
- read_error_i=1 during POP: error_o goes to 1 and the FSM returns to IDLE. A later enable_i=1 does not leave IDLE until reset.
- word_count_o at 0xFFFF: one more handshake wraps it to 0x0000.
